red_pitaya_rst_seq: RTL and testbench
=====================================

# red_pitaya_rst_seq

PLL reset/lock controller that drives the PLL `RST` input and consumes its asynchronous `LOCKED` output. It pulses the PLL reset, waits for lock with a timeout and retry, and requires a stable-lock hold period before releasing the system reset. It also detects loss of lock and re-sequences. It sits between the board reset and the PLL, and feeds `sys_rstn` to all logic clocked from PLL outputs.

## Interface
- `RST_PULSE`, 16: cycles `pll_rst` is held high per attempt (≥1).
- `LOCK_TIMEOUT`, 100000: cycles to wait for lock before a retry (≥1).
- `HOLD`, 256: consecutive synchronized-locked cycles required before release (≥1).
- `CW`, 20: width of the shared cycle counter; must hold max(RST_PULSE, LOCK_TIMEOUT, HOLD).
- `clk`  in  1  free-running reference clock (same clock feeding the PLL input).
- `rstn`  in  1  reset, asynchronous assert, active-low.
- `pll_locked`  in  1  PLL lock flag, asynchronous to `clk`.
- `clr`  in  1  synchronous pulse; clears `retry_cnt` and `loss_cnt`.
- `pll_rst`  out  1  active-high PLL reset.
- `sys_rstn`  out  1  active-low system reset; 1 only in RUN.
- `state`  out  2  current FSM state (package encoding).
- `retry_cnt`  out  8  saturating count of lock timeouts.
- `loss_cnt`  out  8  saturating count of lock losses in RUN.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to produce `locked_s`. All decisions use `locked_s`.
- FSM states: PRST=0, WAIT=1, HOLD=2, RUN=3. A single counter `cnt` is cleared on every state entry.
- **PRST**: `pll_rst`=1. After RST_PULSE cycles, go to WAIT.
- **WAIT**: `pll_rst`=0.
  - If `locked_s`=1, go to HOLD.
  - Otherwise, after LOCK_TIMEOUT cycles, go to PRST and increment `retry_cnt`.
- **HOLD**:
  - If `locked_s`=0, return to WAIT. `cnt` clears; no counter increments.
  - After HOLD consecutive `locked_s`=1 cycles, go to RUN.
- **RUN**: `sys_rstn`=1. On a lock-loss condition, go to PRST and increment `loss_cnt`.
- Counters saturate at 255.
- When `clr` and an increment occur in the same cycle, the counter becomes 1.
- When `clr` occurs alone, the counter becomes 0.
- Reset values: state=PRST, `pll_rst`=1, `sys_rstn`=0, `retry_cnt`=0, `loss_cnt`=0, `cnt`=0, synchronizer flops=0.
- `rstn` low in any state immediately forces reset values, including mid-RUN: `sys_rstn` drops asynchronously.

## Timing
- All outputs are registered. `pll_rst` and `sys_rstn` are glitch-free flops.
- After `rstn` rises, `pll_rst` stays high for exactly RST_PULSE cycles, then falls.
- Lock latency is 2 cycles through the synchronizer plus 1 cycle for the WAIT→HOLD transition.
- `sys_rstn` rises HOLD cycles after HOLD entry, i.e. at least HOLD+3 cycles after `pll_locked` rises.
- A lock drop in RUN deasserts `sys_rstn` (0) in the same cycle the state leaves RUN.
  - Without deglitch, this is 3 cycles after `pll_locked` falls.
- `pll_rst` is 0 in WAIT, HOLD and RUN.
- `pll_rst` and `sys_rstn` are never both 1.

## Configuration
- `RED_PITAYA_RST_SEQ_DEGLITCH_EN` defined: lock loss in RUN requires `locked_s`=0 for 4 consecutive cycles. Shorter drops are ignored and do not count.
- Macro undefined: a single `locked_s`=0 cycle in RUN is a loss.
- WAIT and HOLD behaviour is identical in both builds.

## Structure
- Package `red_pitaya_rst_seq_pkg`:
  - state enum typedef (2-bit, encodings above);
  - deglitch length constant (4);
  - counter saturation constant (255).
- Sub-module `red_pitaya_sync`: 2-flop synchronizer, parameterized width, async active-low reset to 0. It is reused for other async status inputs.

## Test plan
Bench parameters: RST_PULSE=4, LOCK_TIMEOUT=32, HOLD=8.
- Release `rstn`, raise `pll_locked` 10 cycles later → `pll_rst` high 4 cycles then low; `sys_rstn` rises exactly 11 cycles after `pll_locked` rises; `retry_cnt`=0.
- Never assert `pll_locked` → PRST/WAIT loops every 36 cycles; `retry_cnt` increments per loop and stays at 255 after 300 loops.
- Drop `pll_locked` for 1 cycle at HOLD count 5 → return to WAIT, re-enter HOLD; `sys_rstn` rises only after 8 fresh locked cycles; no counter changes.
- In RUN, drop `pll_locked` for 2 cycles:
  - macro undefined → `sys_rstn`=0, state=PRST, `loss_cnt`=1;
  - macro defined → stays RUN, `loss_cnt`=0.
  - With the macro defined, a 4-cycle drop → `loss_cnt`=1.
- Pulse `clr` in the same cycle as a timeout → `retry_cnt`=1. A `clr` pulse alone → 0.
- Assert `rstn`=0 mid-RUN → `sys_rstn`=0 and `pll_rst`=1 without a clock edge; counters are 0.

Source files
------------

// File: rtl/red_pitaya_rst_seq_pkg.sv
// Shared types and constants for the PLL reset/lock sequencer.
package red_pitaya_rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_PRST = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } state_e;

  // Consecutive unlocked cycles in RUN that count as a real loss (deglitch build)
  localparam int unsigned DEGLITCH_LEN = 4;

  // Saturation value of the retry/loss event counters
  localparam logic [7:0] CNT_SAT = 8'd255;

  // Next value of a saturating event counter; clr wins over hold, but an
  // increment coinciding with clr still registers as the first new event.
  function automatic logic [7:0] evt_cnt_next(input logic [7:0] q,
                                              input logic       inc,
                                              input logic       clr);
    logic [7:0] n;
    n = q;
    if (clr) begin
      n = inc ? 8'd1 : 8'd0;
    end else if (inc && (q != CNT_SAT)) begin
      n = q + 8'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/red_pitaya_rst_seq_if.sv
// Status/control bundle between the reset sequencer and its consumer.
interface red_pitaya_rst_seq_if;
  logic       pll_locked;
  logic       clr;
  logic       pll_rst;
  logic       sys_rstn;
  logic [1:0] state;
  logic [7:0] retry_cnt;
  logic [7:0] loss_cnt;

  modport master (
    input  pll_locked, clr,
    output pll_rst, sys_rstn, state, retry_cnt, loss_cnt
  );

  modport slave (
    output pll_locked, clr,
    input  pll_rst, sys_rstn, state, retry_cnt, loss_cnt
  );
endinterface

// File: rtl/red_pitaya_sync.sv
// Two-flop synchronizer for asynchronous status inputs; resets to 0.
module red_pitaya_sync #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Two-stage capture of the asynchronous input
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/red_pitaya_rst_seq.sv
// PLL reset/lock sequencer: pulses pll_rst, waits for lock with timeout and
// retry, requires a stable-lock hold period, then releases sys_rstn.
// Optional build macro: RED_PITAYA_RST_SEQ_DEGLITCH_EN (lock loss in RUN must
// persist DEGLITCH_LEN cycles before it re-sequences).
module red_pitaya_rst_seq
  import red_pitaya_rst_seq_pkg::*;
#(
  parameter int unsigned RST_PULSE    = 16,
  parameter int unsigned LOCK_TIMEOUT = 100000,
  parameter int unsigned HOLD         = 256,
  parameter int unsigned CW           = 20
) (
  input  logic                   clk,
  input  logic                   rstn,
  red_pitaya_rst_seq_if.master   bus
);

  localparam logic [CW-1:0] PULSE_LAST = CW'(RST_PULSE - 1);
  localparam logic [CW-1:0] TOUT_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD - 1);
`ifdef RED_PITAYA_RST_SEQ_DEGLITCH_EN
  localparam logic [CW-1:0] DGL_LAST   = CW'(DEGLITCH_LEN - 1);
`endif

  logic          locked_s;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pll_rst_q, pll_rst_d;
  logic          sys_rstn_q, sys_rstn_d;
  logic [7:0]    retry_cnt_q, retry_cnt_d;
  logic [7:0]    loss_cnt_q, loss_cnt_d;
  logic          retry_inc;
  logic          loss_inc;

  red_pitaya_sync #(.W(1)) u_lock_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (bus.pll_locked),
    .q    (locked_s)
  );

  // Next-state, shared counter and event strobes
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    retry_inc = 1'b0;
    loss_inc  = 1'b0;
    case (state_q)
      ST_PRST: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      end
      ST_WAIT: begin
        if (locked_s) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == TOUT_LAST) begin
          state_d   = ST_PRST;
          cnt_d     = '0;
          retry_inc = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!locked_s) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
`ifdef RED_PITAYA_RST_SEQ_DEGLITCH_EN
        // In RUN the shared counter tracks consecutive unlocked cycles
        if (!locked_s) begin
          if (cnt_q == DGL_LAST) begin
            state_d  = ST_PRST;
            cnt_d    = '0;
            loss_inc = 1'b1;
          end
        end else begin
          cnt_d = '0;
        end
`else
        cnt_d = '0;
        if (!locked_s) begin
          state_d  = ST_PRST;
          loss_inc = 1'b1;
        end
`endif
      end
      default: begin
        state_d = ST_PRST;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered outputs follow the next state so they change with the state flop
  always_comb begin
    pll_rst_d   = (state_d == ST_PRST);
    sys_rstn_d  = (state_d == ST_RUN);
    retry_cnt_d = evt_cnt_next(retry_cnt_q, retry_inc, bus.clr);
    loss_cnt_d  = evt_cnt_next(loss_cnt_q, loss_inc, bus.clr);
  end

  // State, counters and output flops with asynchronous reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_PRST;
      cnt_q       <= '0;
      pll_rst_q   <= 1'b1;
      sys_rstn_q  <= 1'b0;
      retry_cnt_q <= '0;
      loss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pll_rst_q   <= pll_rst_d;
      sys_rstn_q  <= sys_rstn_d;
      retry_cnt_q <= retry_cnt_d;
      loss_cnt_q  <= loss_cnt_d;
    end
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.sys_rstn  = sys_rstn_q;
  assign bus.state     = state_q;
  assign bus.retry_cnt = retry_cnt_q;
  assign bus.loss_cnt  = loss_cnt_q;

endmodule

// File: tb/tb_red_pitaya_rst_seq.sv
// Directed bench for the PLL reset/lock sequencer (RST_PULSE=4,
// LOCK_TIMEOUT=32, HOLD=8); expectations are queued then drained and compared.
module tb_red_pitaya_rst_seq;

  localparam int SIG_STATE = 0;
  localparam int SIG_PRST  = 1;
  localparam int SIG_SRSTN = 2;
  localparam int SIG_RETRY = 3;
  localparam int SIG_LOSS  = 4;

  typedef struct {
    string       tag;
    int          sig;
    logic [31:0] exp;
  } exp_t;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;
  exp_t sb[$];

  red_pitaya_rst_seq_if bus ();

  red_pitaya_rst_seq #(
    .RST_PULSE    (4),
    .LOCK_TIMEOUT (32),
    .HOLD         (8),
    .CW           (20)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      SIG_STATE: return {30'd0, bus.state};
      SIG_PRST:  return {31'd0, bus.pll_rst};
      SIG_SRSTN: return {31'd0, bus.sys_rstn};
      SIG_RETRY: return {24'd0, bus.retry_cnt};
      SIG_LOSS:  return {24'd0, bus.loss_cnt};
      default:   return 32'hdead_beef;
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sig, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sig);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rstn           = 1'b0;
    bus.pll_locked = 1'b0;
    bus.clr        = 1'b0;

    // Reset state
    tick(3);
    expect_val("rst_state", SIG_STATE, 0);
    expect_val("rst_pll_rst", SIG_PRST, 1);
    expect_val("rst_sys_rstn", SIG_SRSTN, 0);
    expect_val("rst_retry", SIG_RETRY, 0);
    expect_val("rst_loss", SIG_LOSS, 0);
    drain();

    // Normal bring-up: pll_rst pulse, lock 10 cycles after release
    rstn = 1'b1;
    tick(3);
    expect_val("pulse_hi", SIG_PRST, 1);
    drain();
    tick(1);
    expect_val("pulse_lo", SIG_PRST, 0);
    expect_val("wait_state", SIG_STATE, 1);
    drain();
    tick(6);
    bus.pll_locked = 1'b1;
    tick(10);
    expect_val("srstn_early", SIG_SRSTN, 0);
    expect_val("hold_state", SIG_STATE, 2);
    drain();
    tick(1);
    expect_val("srstn_rise", SIG_SRSTN, 1);
    expect_val("run_state", SIG_STATE, 3);
    expect_val("run_pll_rst", SIG_PRST, 0);
    expect_val("run_retry", SIG_RETRY, 0);
    drain();

    // Two-cycle lock drop in RUN
    bus.pll_locked = 1'b0;
    tick(2);
    bus.pll_locked = 1'b1;
    tick(1);
`ifdef RED_PITAYA_RST_SEQ_DEGLITCH_EN
    tick(3);
    expect_val("drop2_state", SIG_STATE, 3);
    expect_val("drop2_srstn", SIG_SRSTN, 1);
    expect_val("drop2_loss", SIG_LOSS, 0);
    drain();
    // Four-cycle drop is a real loss
    bus.pll_locked = 1'b0;
    tick(4);
    bus.pll_locked = 1'b1;
    tick(2);
    expect_val("drop4_state", SIG_STATE, 0);
    expect_val("drop4_srstn", SIG_SRSTN, 0);
    expect_val("drop4_loss", SIG_LOSS, 1);
    drain();
    tick(20);
`else
    expect_val("drop2_state", SIG_STATE, 0);
    expect_val("drop2_srstn", SIG_SRSTN, 0);
    expect_val("drop2_pll_rst", SIG_PRST, 1);
    expect_val("drop2_loss", SIG_LOSS, 1);
    drain();
    tick(20);
`endif
    expect_val("relock_state", SIG_STATE, 3);
    expect_val("relock_srstn", SIG_SRSTN, 1);
    drain();

    // Asynchronous reset mid-RUN, no clock edge
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    expect_val("arst_srstn", SIG_SRSTN, 0);
    expect_val("arst_pll_rst", SIG_PRST, 1);
    expect_val("arst_state", SIG_STATE, 0);
    expect_val("arst_loss", SIG_LOSS, 0);
    expect_val("arst_retry", SIG_RETRY, 0);
    drain();

    // Lock drop in HOLD at count 5 (pll_locked held through reset)
    tick(2);
    bus.pll_locked = 1'b1;
    rstn = 1'b1;
    tick(8);
    bus.pll_locked = 1'b0;
    tick(1);
    bus.pll_locked = 1'b1;
    tick(2);
    expect_val("hdrop_wait", SIG_STATE, 1);
    drain();
    tick(1);
    expect_val("hdrop_rehold", SIG_STATE, 2);
    drain();
    tick(7);
    expect_val("hdrop_srstn_early", SIG_SRSTN, 0);
    drain();
    tick(1);
    expect_val("hdrop_srstn", SIG_SRSTN, 1);
    expect_val("hdrop_retry", SIG_RETRY, 0);
    expect_val("hdrop_loss", SIG_LOSS, 0);
    drain();

    // Never lock: 36-cycle retry loop and saturation
    bus.pll_locked = 1'b0;
    rstn = 1'b0;
    tick(2);
    rstn = 1'b1;
    tick(35);
    expect_val("to_pre_retry", SIG_RETRY, 0);
    expect_val("to_pre_state", SIG_STATE, 1);
    drain();
    tick(1);
    expect_val("to1_retry", SIG_RETRY, 1);
    expect_val("to1_state", SIG_STATE, 0);
    expect_val("to1_pll_rst", SIG_PRST, 1);
    drain();
    tick(36);
    expect_val("to2_retry", SIG_RETRY, 2);
    drain();
    tick(36 * 298);
    expect_val("to300_retry", SIG_RETRY, 255);
    drain();
    tick(36);
    expect_val("to301_retry", SIG_RETRY, 255);
    drain();

    // clr coinciding with a timeout, then clr alone
    tick(35);
    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;
    expect_val("clr_inc_retry", SIG_RETRY, 1);
    drain();
    tick(3);
    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;
    expect_val("clr_only_retry", SIG_RETRY, 0);
    expect_val("clr_only_loss", SIG_LOSS, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
